stackcalc_sequencer: RTL and testbench

Instruction sequencer for the stack calculator: accepts 8-bit instruction bytes (opcode + immediate nibble) over a valid/ready handshake and drives the 4-deep, 4-bit operand stack through its push/pop port. It sits directly upstream of the stack register and consumes its top and second words. It computes 4-bit ALU results, tracks stack depth, flags overflow, underflow and illegal opcodes, and presents OUT results to the pin-facing wrapper.

---
 rtl/stackcalc_pkg.sv | 63 ++++++
 rtl/stackcalc_if.sv | 9 +
 rtl/stackcalc_alu.sv | 28 ++
 rtl/stackcalc_sequencer.sv | 123 ++++++++++++
 tb/tb_stackcalc_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stackcalc_pkg.sv
// Shared types and helpers for the stack calculator sequencer.
// STACKCALC_MUL_EN makes opcode A a legal MUL; without it opcode A is illegal.
package stackcalc_pkg;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef logic [DEPTH_W-1:0] depth_t;

    localparam depth_t DEPTH_MAX = depth_t'(DEPTH);

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_PUSH   = 4'h1,
        OP_POP    = 4'h2,
        OP_DUP    = 4'h3,
        OP_SWAP   = 4'h4,
        OP_ADD    = 4'h5,
        OP_SUB    = 4'h6,
        OP_AND    = 4'h7,
        OP_OR     = 4'h8,
        OP_XOR    = 4'h9,
        OP_MUL    = 4'hA,
        OP_OUT    = 4'hB,
        OP_CLRERR = 4'hC
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP1,
        ST_POP2,
        ST_PUSHA,
        ST_PUSHB
    } state_e;

    function automatic logic is_binary(opcode_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
`ifdef STACKCALC_MUL_EN
            OP_MUL:                                return 1'b1;
`endif
            default:                               return 1'b0;
        endcase
    endfunction

    // Opcode is known and the stack holds enough words for it to run.
    function automatic logic op_legal(opcode_e op, depth_t d);
        case (op)
            OP_NOP, OP_CLRERR: return 1'b1;
            OP_PUSH:           return d < DEPTH_MAX;
            OP_POP, OP_OUT:    return d >= depth_t'(1);
            OP_DUP:            return (d >= depth_t'(1)) && (d < DEPTH_MAX);
            OP_SWAP:           return d >= depth_t'(2);
            default:           return is_binary(op) && (d >= depth_t'(2));
        endcase
    endfunction

endpackage

// File: rtl/stackcalc_if.sv
// Instruction-byte valid/ready channel feeding the sequencer.
interface stackcalc_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/stackcalc_alu.sv
// Combinational 4-bit ALU: result = opb op opa, truncated to a nibble.
// The MUL branch exists only when STACKCALC_MUL_EN is defined.
module stackcalc_alu
    import stackcalc_pkg::*;
(
    input  opcode_e    op,
    input  logic [3:0] opa,
    input  logic [3:0] opb,
    output logic [3:0] result
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = opb + opa;
            OP_SUB:  result = opb - opa;
            OP_AND:  result = opb & opa;
            OP_OR:   result = opb | opa;
            OP_XOR:  result = opb ^ opa;
`ifdef STACKCALC_MUL_EN
            OP_MUL:  result = opb * opa;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stackcalc_sequencer.sv
// Stack calculator sequencer: decodes instruction bytes and drives the operand stack.
// Define STACKCALC_MUL_EN to enable the MUL opcode (A).
module stackcalc_sequencer
    import stackcalc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    stackcalc_if.slave bus,
    input  logic [3:0] stk_top,
    input  logic [3:0] stk_second,
    output logic       stk_en,
    output logic       stk_mode,
    output logic [3:0] stk_word,
    output depth_t     depth,
    output logic [3:0] out_word,
    output logic       out_valid,
    output logic       err
);

    state_e     state, state_nx;
    opcode_e    op_q, op_in;
    logic [3:0] opa_q, opb_q, imm_in, alu_res;
    logic       accept, legal;

    logic       en_nx, mode_nx, ov_nx, err_nx;
    logic [3:0] word_nx, ow_nx;
    depth_t     depth_nx;

    assign op_in        = opcode_e'(bus.in_instr[OP_MSB:OP_LSB]);
    assign imm_in       = bus.in_instr[IMM_MSB:IMM_LSB];
    assign bus.in_ready = (state == ST_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign legal        = op_legal(op_in, depth);

    stackcalc_alu u_alu (
        .op     (op_q),
        .opa    (opa_q),
        .opb    (opb_q),
        .result (alu_res)
    );

    // NOTE: state and captured operands use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op_in;
                opa_q <= stk_top;
                opb_q <= stk_second;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept && legal) begin
                    case (op_in)
                        OP_PUSH, OP_DUP: state_nx = ST_PUSHA;
                        OP_POP, OP_SWAP: state_nx = ST_POP1;
                        default:         state_nx = is_binary(op_in) ? ST_POP1 : ST_IDLE;
                    endcase
                end
            end
            ST_POP1:  state_nx = (op_q == OP_POP) ? ST_IDLE : ST_POP2;
            ST_POP2:  state_nx = ST_PUSHA;
            ST_PUSHA: state_nx = (op_q == OP_SWAP) ? ST_PUSHB : ST_IDLE;
            ST_PUSHB: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Stack strobes are registered from the next state so they line up with that state's cycle.
    always_comb begin
        en_nx    = state_nx inside {ST_POP1, ST_POP2, ST_PUSHA, ST_PUSHB};
        mode_nx  = state_nx inside {ST_PUSHA, ST_PUSHB};
        word_nx  = stk_word;
        if (state_nx == ST_PUSHA) begin
            if (state == ST_IDLE) word_nx = (op_in == OP_PUSH) ? imm_in : stk_top;
            else                  word_nx = (op_q == OP_SWAP) ? opa_q : alu_res;
        end else if (state_nx == ST_PUSHB) begin
            word_nx = opb_q;
        end

        ov_nx  = accept && legal && (op_in == OP_OUT);
        ow_nx  = ov_nx ? stk_top : out_word;
        err_nx = err;
        if (accept) begin
            if (!legal)                   err_nx = 1'b1;
            else if (op_in == OP_CLRERR)  err_nx = 1'b0;
        end

        depth_nx = depth;
        if (stk_en) depth_nx = stk_mode ? depth + depth_t'(1) : depth - depth_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_en    <= 1'b0;
            stk_mode  <= 1'b0;
            stk_word  <= '0;
            depth     <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            stk_en    <= en_nx;
            stk_mode  <= mode_nx;
            stk_word  <= word_nx;
            depth     <= depth_nx;
            out_word  <= ow_nx;
            out_valid <= ov_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_stackcalc_sequencer.sv
// Self-checking bench for stackcalc_sequencer: stack-level model plus directed vectors.
// Honours STACKCALC_MUL_EN the same way as the design.
module tb_stackcalc_sequencer;
    import stackcalc_pkg::*;

`ifdef STACKCALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] stk_top, stk_second, stk_word, out_word;
    logic       stk_en, stk_mode, out_valid, err;
    depth_t     depth;

    always #5 clk = ~clk;

    stackcalc_if bus ();

    stackcalc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .stk_top    (stk_top),
        .stk_second (stk_second),
        .stk_en     (stk_en),
        .stk_mode   (stk_mode),
        .stk_word   (stk_word),
        .depth      (depth),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .err        (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stack register environment sharing rst_n with the DUT; logs every strobe.
    typedef struct { logic mode; logic [3:0] word; } strobe_t;
    logic [3:0] st [4];
    int         sp;
    strobe_t    slog [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= 0;
        else if (stk_en === 1'b1) begin
            if (stk_mode) begin
                if (sp < 4) begin
                    st[sp] <= stk_word;
                    sp     <= sp + 1;
                end
            end else if (sp > 0) sp <= sp - 1;
            slog.push_back('{stk_mode, stk_word});
        end
    end

    assign stk_top    = (sp > 0) ? st[sp-1] : 4'h0;
    assign stk_second = (sp > 1) ? st[sp-2] : 4'h0;

    int cyc = 0;
    int ov_cnt = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (out_valid === 1'b1) ov_cnt++;

    // Model: a plain queue stack plus a per-cycle list of expected outputs after each accept.
    typedef struct {
        logic ready, en, mode, chk_word, ov, er;
        logic [3:0] word, ow;
        int depth;
    } exp_t;

    exp_t       q [$];
    logic [3:0] m_stk [$];
    logic [3:0] m_out = 4'h0;
    logic       m_err = 1'b0;
    logic       check_en = 1'b0;

    function automatic exp_t steady();
        exp_t e;
        e.ready = 1'b1; e.en = 1'b0; e.mode = 1'b0; e.chk_word = 1'b0; e.word = 4'h0;
        e.depth = m_stk.size(); e.ov = 1'b0; e.ow = m_out; e.er = m_err;
        return e;
    endfunction

    task automatic model_accept(input logic [7:0] b);
        int         op, d, cur;
        logic [3:0] imm, a, bv, r;
        logic       ok, pulse_ov;
        logic       pushes [$];
        logic [3:0] words [$];
        exp_t       e;
        op  = int'(b[7:4]);
        imm = b[3:0];
        d   = m_stk.size();
        a   = (d > 0) ? m_stk[d-1] : 4'h0;
        bv  = (d > 1) ? m_stk[d-2] : 4'h0;
        case (op)
            0, 12:          ok = 1'b1;
            1:              ok = d < 4;
            2, 11:          ok = d >= 1;
            3:              ok = d >= 1 && d <= 3;
            4, 5, 6, 7, 8, 9: ok = d >= 2;
            10:             ok = MUL_EN && d >= 2;
            default:        ok = 1'b0;
        endcase
        pulse_ov = 1'b0;
        if (!ok) m_err = 1'b1;
        else begin
            case (op)
                1: begin pushes.push_back(1); words.push_back(imm); end
                2: begin pushes.push_back(0); words.push_back(0); end
                3: begin pushes.push_back(1); words.push_back(a); end
                4: begin
                    pushes = '{0, 0, 1, 1};
                    words  = '{4'h0, 4'h0, a, bv};
                end
                5, 6, 7, 8, 9, 10: begin
                    case (op)
                        5:       r = 4'((int'(bv) + int'(a)) % 16);
                        6:       r = 4'((int'(bv) - int'(a) + 16) % 16);
                        7:       r = bv & a;
                        8:       r = bv | a;
                        9:       r = bv ^ a;
                        default: r = 4'((int'(bv) * int'(a)) % 16);
                    endcase
                    pushes = '{0, 0, 1};
                    words  = '{4'h0, 4'h0, r};
                end
                11: begin m_out = a; pulse_ov = 1'b1; end
                12: m_err = 1'b0;
                default: ;
            endcase
        end
        if (pushes.size() == 0) begin
            e = steady();
            e.ov = pulse_ov;
            q.push_back(e);
        end else begin
            cur = d;
            for (int i = 0; i < pushes.size(); i++) begin
                e = steady();
                e.ready = 1'b0; e.en = 1'b1; e.mode = pushes[i];
                e.chk_word = pushes[i]; e.word = words[i]; e.depth = cur;
                q.push_back(e);
                if (pushes[i]) begin m_stk.push_back(words[i]); cur++; end
                else begin void'(m_stk.pop_back()); cur--; end
            end
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (check_en) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = steady();
            check("in_ready", bus.in_ready, e.ready);
            check("stk_en", stk_en, e.en);
            if (e.en) check("stk_mode", stk_mode, e.mode);
            if (e.chk_word) check("stk_word", stk_word, e.word);
            check("depth", depth, e.depth);
            check("out_valid", out_valid, e.ov);
            check("out_word", out_word, e.ow);
            check("err", err, e.er);
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: instr %0h not accepted within %0d cycles", b, n);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(b);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (bus.in_ready !== 1'b1 && busy < 50) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        q.delete();
        m_stk.delete();
        m_err = 1'b0;
        m_out = 4'h0;
        rst_n    = 1'b1;
        check_en = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_stk_en"}, stk_en, 0);
        check({tag, "_stk_mode"}, stk_mode, 0);
        check({tag, "_stk_word"}, stk_word, 0);
        check({tag, "_depth"}, depth, 0);
        check({tag, "_out_word"}, out_word, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int busy, c0;
        strobe_t exp_log [$];
        bus.in_valid = 1'b0;
        bus.in_instr = 8'h00;
        idle(2);
        check_reset_values("reset");
        rst_n    = 1'b1;
        check_en = 1'b1;
        idle(1);

        // PUSH 3, PUSH 5, ADD, OUT
        slog.delete();
        c0 = ov_cnt;
        send(8'h13); send(8'h15); send(8'h50); send(8'hB0);
        idle(3);
        exp_log = '{'{1'b1, 4'h3}, '{1'b1, 4'h5}, '{1'b0, 4'h0}, '{1'b0, 4'h0}, '{1'b1, 4'h8}};
        check("add_log_len", slog.size(), 5);
        for (int i = 0; i < 5 && i < slog.size(); i++) begin
            check("add_log_mode", slog[i].mode, exp_log[i].mode);
            if (exp_log[i].mode) check("add_log_word", slog[i].word, exp_log[i].word);
        end
        check("add_out_word", out_word, 4'h8);
        check("add_out_pulses", ov_cnt - c0, 1);
        check("add_depth", depth, 1);
        check("add_err", err, 0);

        // PUSH 2, PUSH 7, SUB, OUT; then PUSH F, PUSH 3, MUL
        send(8'h12); send(8'h17); send(8'h60); send(8'hB0);
        idle(2);
        check("sub_out_word", out_word, 4'hB);
        send(8'h1F); send(8'h13); send(8'hA0);
        idle(4);
`ifdef STACKCALC_MUL_EN
        check("mul_top", stk_top, 4'hD);
        check("mul_depth", depth, 3);
        check("mul_err", err, 0);
`else
        check("mul_err", err, 1);
        check("mul_depth", depth, 4);
`endif

        // PUSH 1, PUSH 2, SWAP
        do_reset();
        slog.delete();
        send(8'h11); send(8'h12); send(8'h40);
        wait_idle(busy);
        check("swap_busy", busy, 4);
        idle(1);
        check("swap_top", stk_top, 4'h1);
        check("swap_second", stk_second, 4'h2);
        exp_log = '{'{1'b1, 4'h1}, '{1'b1, 4'h2}, '{1'b0, 4'h0}, '{1'b0, 4'h0},
                    '{1'b1, 4'h2}, '{1'b1, 4'h1}};
        check("swap_log_len", slog.size(), 6);
        for (int i = 0; i < 6 && i < slog.size(); i++) begin
            check("swap_log_mode", slog[i].mode, exp_log[i].mode);
            if (exp_log[i].mode) check("swap_log_word", slog[i].word, exp_log[i].word);
        end

        // Underflow, CLRERR, overflow
        do_reset();
        slog.delete();
        send(8'h20);
        idle(2);
        check("underflow_err", err, 1);
        check("underflow_strobes", slog.size(), 0);
        check("underflow_depth", depth, 0);
        send(8'hC0);
        idle(2);
        check("clrerr_err", err, 0);
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h15);
        idle(2);
        check("overflow_err", err, 1);
        check("overflow_depth", depth, 4);

        // Illegal opcode, then back-to-back NOPs
        do_reset();
        send(8'hE0);
        wait_idle(busy);
        check("illegal_busy", busy, 0);
        idle(1);
        check("illegal_err", err, 1);
        c0 = cyc;
        repeat (4) send(8'h00);
        check("nop_b2b_cycles", cyc - c0, 4);
        idle(2);

        // Reset asserted during POP2 of ADD
        do_reset();
        send(8'h11); send(8'h12);
        idle(3);
        check_en = 1'b0;
        bus.in_instr = 8'h50;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midreset_busy_before", stk_en, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        q.delete();
        m_stk.delete();
        m_err = 1'b0;
        m_out = 4'h0;
        rst_n    = 1'b1;
        check_en = 1'b1;
        idle(1);
        send(8'h14);
        idle(2);
        check("midreset_push_depth", depth, 1);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
